neg_run_detector: RTL
=====================

// Module: neg_run_detector
// PURPOSE
//  Streaming sign monitor; sits directly after the 8-bit less-than-zero flag stage in the datapath.
//  Accepts signed 8-bit samples over a valid/ready handshake and takes the sign from bit 7.
//  Raises an alarm after SET_COUNT consecutive negative samples.
//  Clears the alarm after CLR_COUNT consecutive non-negative samples (hysteresis).
//  Each alarm transition is reported as one event on an acknowledged event port.
//  Also keeps a saturating count of all negative samples accepted.
// PARAMETERS
//  SET_COUNT  4   consecutive negatives needed to raise the alarm (legal range 1..255)
//  CLR_COUNT  2   consecutive non-negatives needed to clear the alarm (legal range 1..255)
//  CNT_W      16  width of NEG_COUNT (and MAX_RUN when present)
// PORTS
//  CLK        in   1      clock; all state updates on the rising edge
//  RST        in   1      reset, synchronous, active-high
//  A_IN       in   8      signed sample; negative when A_IN[7]=1
//  VALID_IN   in   1      A_IN is valid this cycle
//  READY_OUT  out  1      block can accept a sample; equals ~EVT_VALID
//  ALARM      out  1      registered alarm level
//  EVT_VALID  out  1      event pending; held high until acknowledged
//  EVT_CODE   out  1      1 = alarm set, 0 = alarm cleared; stable while EVT_VALID=1
//  EVT_ACK    in   1      consumer acknowledge; only meaningful while EVT_VALID=1
//  NEG_COUNT  out  CNT_W  saturating count of accepted negative samples
// BEHAVIOUR
//  Transfer rule: a sample is accepted only in a cycle where VALID_IN & READY_OUT. Other cycles hold all state.
//  Reset: on RST=1 at a clock edge, every output and register goes to 0.
//   This includes ALARM, EVT_*, NEG_COUNT, MAX_RUN, run/clr counters and the FSM, which returns to S_CLEAR.
//   Reset outranks every other event; a pending event is dropped.
//  Latency: results of a sample accepted at edge t are visible immediately after edge t.
//   This covers ALARM, EVT_VALID and NEG_COUNT.
//  FSM. run and clr are internal 8-bit counters. Transitions occur only on accepted samples.
//   S_CLEAR: on a negative sample, run=1.
//    If SET_COUNT=1: go to S_ALARM and emit a set event. Otherwise go to S_ARMING.
//    Non-negative samples leave the state unchanged.
//   S_ARMING: on a negative sample, run++.
//    If run reaches SET_COUNT: go to S_ALARM, set ALARM=1, emit a set event.
//    On a non-negative sample: run=0 and return to S_CLEAR. No event.
//   S_ALARM: a negative sample leaves the state unchanged.
//    On a non-negative sample, clr=1.
//    If CLR_COUNT=1: go to S_CLEAR, set ALARM=0, emit a clear event. Otherwise go to S_RELEASING.
//   S_RELEASING: on a non-negative sample, clr++.
//    If clr reaches CLR_COUNT: go to S_CLEAR, set ALARM=0, run=0, emit a clear event.
//    On a negative sample: clr=0 and return to S_ALARM. No event.
//  Emitting an event: EVT_VALID=1 and EVT_CODE loaded, both on the same edge as ALARM changes.
//  Event handshake and stall:
//   EVT_VALID & EVT_ACK at an edge clears EVT_VALID at that edge.
//   READY_OUT is low while EVT_VALID=1, so the input stalls until the event is consumed.
//   A second event can never be lost.
//   EVT_ACK while EVT_VALID=0 is ignored.
//  NEG_COUNT increments on every accepted negative sample and saturates at 2^CNT_W-1 (no wrap).
//  Sign boundaries: 8'h80 (-128) and 8'hFF (-1) are negative; 8'h00 and 8'h7F are non-negative.
// CONFIGURATION
//  Macro NEG_RUN_MAXLEN_EN.
//  Defined:
//   Adds output MAX_RUN (CNT_W bits): length of the longest run of consecutive accepted negatives.
//   A live run counter (CNT_W bits, saturating) tracks the current run.
//   MAX_RUN is updated on the same edge whenever the live run exceeds it.
//   MAX_RUN resets to 0 and saturates at 2^CNT_W-1.
//  Not defined: the MAX_RUN port and its logic are absent. All other behaviour is identical.
// STRUCTURE
//  Shared package / header neg_run_defs: FSM state encodings and the event codes.
//   S_CLEAR=2'd0, S_ARMING=2'd1, S_ALARM=2'd2, S_RELEASING=2'd3.
//   EVT_SET=1'b1, EVT_CLR=1'b0.
//  Sub-module sat_counter (parameter W): synchronous reset, inc, clr and value.
//   Saturates at all-ones.
//   Used for NEG_COUNT and for the MAX_RUN live run counter.
// TESTING
//  1. Reset: RST high 2 cycles mid-stream -> every output is 0 after the edge; READY_OUT=1.
//  2. Alarm set (SET_COUNT=4): feed 8'hFF, 8'h80, 8'hF0, 8'h81 with EVT_ACK=0.
//     -> ALARM=1 and EVT_VALID=1 with EVT_CODE=1 after the 4th sample; READY_OUT=0.
//     -> ack -> READY_OUT=1 next cycle.
//  3. Broken run: 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF -> no event, ALARM stays 0, NEG_COUNT=4.
//  4. Hysteresis (CLR_COUNT=2): from alarm, feed 8'h00, 8'hFF, 8'h7F, 8'h01.
//     -> clear event with EVT_CODE=0 only after 8'h01; ALARM=0 at the same edge.
//  5. Stall and saturation:
//     With EVT_VALID held and VALID_IN=1 for 10 cycles -> no sample accepted, NEG_COUNT unchanged.
//     With CNT_W=4, 20 negatives -> NEG_COUNT=4'hF.
//  6. NEG_RUN_MAXLEN_EN: runs of 3, 7 and 2 negatives separated by 8'h00 -> MAX_RUN=7.

Source files
------------

// File: rtl/neg_run_detector_pkg.sv
// Shared definitions for the negative-run detector: FSM state encodings and event codes.
package neg_run_defs;

    typedef enum logic [1:0] {
        S_CLEAR     = 2'd0,
        S_ARMING    = 2'd1,
        S_ALARM     = 2'd2,
        S_RELEASING = 2'd3
    } state_t;

    localparam logic EVT_SET = 1'b1;
    localparam logic EVT_CLR = 1'b0;

endpackage

// File: rtl/neg_run_detector_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    // Clear wins over increment so a run counter restarts cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/neg_run_detector.sv
// Streaming sign monitor with set/clear hysteresis and an acknowledged event port.
// Optional feature: define NEG_RUN_MAXLEN_EN to add the MAX_RUN longest-run output.
module neg_run_detector
    import neg_run_defs::*;
#(
    parameter int SET_COUNT = 4,
    parameter int CLR_COUNT = 2,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       A_IN,
    input  logic             VALID_IN,
    output logic             READY_OUT,
    output logic             ALARM,
    output logic             EVT_VALID,
    output logic             EVT_CODE,
    input  logic             EVT_ACK,
`ifdef NEG_RUN_MAXLEN_EN
    output logic [CNT_W-1:0] MAX_RUN,
`endif
    output logic [CNT_W-1:0] NEG_COUNT
);

    localparam logic [7:0] SET_C = 8'(SET_COUNT);
    localparam logic [7:0] CLR_C = 8'(CLR_COUNT);

    state_t     state;
    logic [7:0] run;
    logic [7:0] clr;
    logic [7:0] run_inc;
    logic [7:0] clr_inc;
    logic       accept;
    logic       is_neg;
    logic       magnitude_unused;

    // Only the sign bit matters; the rest of the sample is deliberately ignored.
    assign is_neg           = A_IN[7];
    assign magnitude_unused = ^A_IN[6:0];

    // A pending event stalls the input so it can never be overwritten.
    assign READY_OUT = ~EVT_VALID;
    assign accept    = VALID_IN & ~EVT_VALID;
    assign run_inc   = run + 8'd1;
    assign clr_inc   = clr + 8'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_CLEAR;
            run       <= 8'd0;
            clr       <= 8'd0;
            ALARM     <= 1'b0;
            EVT_VALID <= 1'b0;
            EVT_CODE  <= 1'b0;
        end else begin
            if (EVT_VALID && EVT_ACK) begin
                EVT_VALID <= 1'b0;
            end
            if (accept) begin
                case (state)
                    S_CLEAR: begin
                        if (is_neg) begin
                            run <= 8'd1;
                            if (SET_COUNT == 1) begin
                                state     <= S_ALARM;
                                ALARM     <= 1'b1;
                                EVT_VALID <= 1'b1;
                                EVT_CODE  <= EVT_SET;
                            end else begin
                                state <= S_ARMING;
                            end
                        end
                    end
                    S_ARMING: begin
                        if (is_neg) begin
                            run <= run_inc;
                            if (run_inc == SET_C) begin
                                state     <= S_ALARM;
                                ALARM     <= 1'b1;
                                EVT_VALID <= 1'b1;
                                EVT_CODE  <= EVT_SET;
                            end
                        end else begin
                            run   <= 8'd0;
                            state <= S_CLEAR;
                        end
                    end
                    S_ALARM: begin
                        if (!is_neg) begin
                            clr <= 8'd1;
                            if (CLR_COUNT == 1) begin
                                state     <= S_CLEAR;
                                run       <= 8'd0;
                                ALARM     <= 1'b0;
                                EVT_VALID <= 1'b1;
                                EVT_CODE  <= EVT_CLR;
                            end else begin
                                state <= S_RELEASING;
                            end
                        end
                    end
                    S_RELEASING: begin
                        if (!is_neg) begin
                            clr <= clr_inc;
                            if (clr_inc == CLR_C) begin
                                state     <= S_CLEAR;
                                run       <= 8'd0;
                                ALARM     <= 1'b0;
                                EVT_VALID <= 1'b1;
                                EVT_CODE  <= EVT_CLR;
                            end
                        end else begin
                            clr   <= 8'd0;
                            state <= S_ALARM;
                        end
                    end
                    default: begin
                        state <= S_CLEAR;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_neg_count (
        .clk   (CLK),
        .rst   (RST),
        .inc   (accept & is_neg),
        .clr   (1'b0),
        .value (NEG_COUNT)
    );

`ifdef NEG_RUN_MAXLEN_EN
    logic [CNT_W-1:0] live_run;
    logic [CNT_W-1:0] live_next;

    sat_counter #(.W(CNT_W)) u_live_run (
        .clk   (CLK),
        .rst   (RST),
        .inc   (accept & is_neg),
        .clr   (accept & ~is_neg),
        .value (live_run)
    );

    // Compare against the post-increment run so MAX_RUN tracks on the same edge.
    assign live_next = (live_run == '1) ? live_run : live_run + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            MAX_RUN <= '0;
        end else if (accept && is_neg && (live_next > MAX_RUN)) begin
            MAX_RUN <= live_next;
        end
    end
`endif

endmodule
